acc_interconnect_stage: RTL and testbench



---
 rtl/acc_pkg.sv | 32 +++
 rtl/acc_interconnect_stage_if.sv | 63 ++++++
 rtl/acc_rsp_arbiter.sv | 77 +++++++
 rtl/acc_interconnect_stage.sv | 158 +++++++++++++++
 tb/tb_acc_interconnect_stage.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/acc_pkg.sv
// Shared types and helpers for the accelerator C-bus interconnect stage:
// request target encoding, address field split and response source count.
package acc_pkg;

  typedef enum logic [1:0] {
    TGT_LOC = 2'd0,
    TGT_NXT = 2'd1,
    TGT_ERR = 2'd2
  } tgt_e;

  // Response sources: the error entry, every local accelerator, the next level.
  function automatic int unsigned num_src(input int unsigned num_rsp);
    return num_rsp + 32'd2;
  endfunction

  function automatic int unsigned addr_hier(input int unsigned addr, input int unsigned acc_w);
    return addr >> acc_w;
  endfunction

  function automatic int unsigned addr_idx(input int unsigned addr, input int unsigned acc_w);
    return addr & ((32'd1 << acc_w) - 32'd1);
  endfunction

  function automatic tgt_e decode_tgt(input int unsigned hier, input int unsigned idx,
                                      input int unsigned level, input int unsigned num_hier,
                                      input int unsigned num_rsp);
    if (hier == level) return (idx < num_rsp) ? TGT_LOC : TGT_ERR;
    if (level + 32'd1 < num_hier) return TGT_NXT;
    return TGT_ERR;
  endfunction

endpackage

// File: rtl/acc_interconnect_stage_if.sv
// Bundle of all request/response channels seen by one interconnect stage.
// Every channel is valid/ready: a transfer happens on a cycle where both are
// high; once valid rises it stays high with a stable payload until ready.
interface acc_interconnect_stage_if #(
  parameter int unsigned NumRsp    = 4,
  parameter int unsigned AddrWidth = 4,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned IdWidth   = 1
);
  logic                        slv_q_valid_i;
  logic                        slv_q_ready_o;
  logic [AddrWidth-1:0]        slv_q_addr_i;
  logic [IdWidth-1:0]          slv_q_id_i;
  logic [31:0]                 slv_q_instr_i;
  logic [3*DataWidth-1:0]      slv_q_rs_i;

  logic [NumRsp-1:0]           loc_q_valid_o;
  logic [NumRsp-1:0]           loc_q_ready_i;
  logic                        nxt_q_valid_o;
  logic                        nxt_q_ready_i;
  logic [AddrWidth-1:0]        q_addr_o;
  logic [IdWidth-1:0]          q_id_o;
  logic [31:0]                 q_instr_o;
  logic [3*DataWidth-1:0]      q_rs_o;

  logic [NumRsp-1:0]           loc_p_valid_i;
  logic [NumRsp-1:0]           loc_p_ready_o;
  logic [NumRsp*DataWidth-1:0] loc_p_data_i;
  logic [NumRsp*IdWidth-1:0]   loc_p_id_i;
  logic [NumRsp-1:0]           loc_p_error_i;

  logic                        nxt_p_valid_i;
  logic                        nxt_p_ready_o;
  logic [DataWidth-1:0]        nxt_p_data_i;
  logic [IdWidth-1:0]          nxt_p_id_i;
  logic                        nxt_p_error_i;

  logic                        slv_p_valid_o;
  logic                        slv_p_ready_i;
  logic [DataWidth-1:0]        slv_p_data_o;
  logic [IdWidth-1:0]          slv_p_id_o;
  logic                        slv_p_error_o;

  modport slave (
    input  slv_q_valid_i, slv_q_addr_i, slv_q_id_i, slv_q_instr_i, slv_q_rs_i,
    input  loc_q_ready_i, nxt_q_ready_i,
    input  loc_p_valid_i, loc_p_data_i, loc_p_id_i, loc_p_error_i,
    input  nxt_p_valid_i, nxt_p_data_i, nxt_p_id_i, nxt_p_error_i, slv_p_ready_i,
    output slv_q_ready_o, loc_q_valid_o, nxt_q_valid_o, q_addr_o, q_id_o, q_instr_o, q_rs_o,
    output loc_p_ready_o, nxt_p_ready_o,
    output slv_p_valid_o, slv_p_data_o, slv_p_id_o, slv_p_error_o
  );

  modport master (
    output slv_q_valid_i, slv_q_addr_i, slv_q_id_i, slv_q_instr_i, slv_q_rs_i,
    output loc_q_ready_i, nxt_q_ready_i,
    output loc_p_valid_i, loc_p_data_i, loc_p_id_i, loc_p_error_i,
    output nxt_p_valid_i, nxt_p_data_i, nxt_p_id_i, nxt_p_error_i, slv_p_ready_i,
    input  slv_q_ready_o, loc_q_valid_o, nxt_q_valid_o, q_addr_o, q_id_o, q_instr_o, q_rs_o,
    input  loc_p_ready_o, nxt_p_ready_o,
    input  slv_p_valid_o, slv_p_data_o, slv_p_id_o, slv_p_error_o
  );
endinterface

// File: rtl/acc_rsp_arbiter.sv
// N-input valid/ready arbiter feeding a one-entry output register.
// Fixed priority (input 0 highest) unless ACC_IC_STAGE_RR_ARB_EN selects round-robin.
module acc_rsp_arbiter #(
  parameter int unsigned NumIn = 6,
  parameter int unsigned Width = 34
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NumIn-1:0]       in_valid_i,
  output logic [NumIn-1:0]       in_ready_o,
  input  logic [NumIn*Width-1:0] in_data_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [Width-1:0]       out_data_o
);
  localparam int unsigned PtrWidth = (NumIn > 1) ? $clog2(NumIn) : 1;

  logic                out_valid_q, out_valid_d;
  logic [Width-1:0]    out_data_q, out_data_d;
  logic [PtrWidth-1:0] ptr_q, ptr_d;
  logic                slot_free;
  logic                gnt_found;
  logic [PtrWidth-1:0] gnt_idx;
  int unsigned         src;

  assign slot_free = ~out_valid_q | out_ready_i;

  // Search starts at the pointer; with the pointer pinned at 0 this is fixed priority.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    src       = 0;
    for (int k = 0; k < NumIn; k++) begin
      src = 32'(ptr_q) + k;
      if (src >= NumIn) src = src - NumIn;
      if (!gnt_found && in_valid_i[src]) begin
        gnt_found = 1'b1;
        gnt_idx   = PtrWidth'(src);
      end
    end
  end

  always_comb begin
    in_ready_o  = '0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    ptr_d       = ptr_q;
    if (slot_free) begin
      out_valid_d = gnt_found;
      if (gnt_found) begin
        in_ready_o[gnt_idx] = 1'b1;
        out_data_d          = in_data_i[32'(gnt_idx)*Width +: Width];
`ifdef ACC_IC_STAGE_RR_ARB_EN
        ptr_d = (gnt_idx == PtrWidth'(NumIn-1)) ? '0 : gnt_idx + 1'b1;
`endif
      end
    end
`ifndef ACC_IC_STAGE_RR_ARB_EN
    ptr_d = '0;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
endmodule

// File: rtl/acc_interconnect_stage.sv
// One level of the accelerator C-bus interconnect: routes requests by address to a
// local accelerator or the next level, and arbitrates responses back upstream.
// Optional ACC_IC_STAGE_RR_ARB_EN switches response arbitration to round-robin.
module acc_interconnect_stage
  import acc_pkg::*;
#(
  parameter int unsigned HierLevel     = 0,
  parameter int unsigned NumHier       = 3,
  parameter int unsigned NumRsp        = 4,
  parameter int unsigned HierAddrWidth = 2,
  parameter int unsigned AccAddrWidth  = 2,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned IdWidth       = 1
) (
  input logic               clk_i,
  input logic               rst_i,
  acc_interconnect_stage_if.slave bus
);
  localparam int unsigned AddrWidth = HierAddrWidth + AccAddrWidth;
  localparam int unsigned NumSrc    = num_src(NumRsp);

  typedef struct packed {
    logic [AddrWidth-1:0]   addr;
    logic [IdWidth-1:0]     id;
    logic [31:0]            instr;
    logic [3*DataWidth-1:0] rs;
  } req_t;

  typedef struct packed {
    logic                 error;
    logic [IdWidth-1:0]   id;
    logic [DataWidth-1:0] data;
  } rsp_t;

  tgt_e                    in_tgt;
  logic [AccAddrWidth-1:0] in_idx;
  logic                    in_acc;
  logic                    held_ready;
  logic                    err_gnt;

  logic                    q_full_q, q_full_d;
  tgt_e                    q_tgt_q, q_tgt_d;
  logic [AccAddrWidth-1:0] q_idx_q, q_idx_d;
  req_t                    q_req_q, q_req_d;
  logic                    err_full_q, err_full_d;
  logic [IdWidth-1:0]      err_id_q, err_id_d;

  logic [NumRsp-1:0]       loc_q_valid;
  logic [NumSrc-1:0]       src_valid, src_ready;
  rsp_t [NumSrc-1:0]       src_rsp;
  rsp_t                    out_rsp;

  always_comb begin
    in_idx = bus.slv_q_addr_i[AccAddrWidth-1:0];
    in_tgt = decode_tgt(addr_hier(32'(bus.slv_q_addr_i), AccAddrWidth),
                        addr_idx(32'(bus.slv_q_addr_i), AccAddrWidth),
                        HierLevel, NumHier, NumRsp);
  end

  always_comb begin
    held_ready = 1'b0;
    if (q_full_q) begin
      if (q_tgt_q == TGT_LOC)      held_ready = bus.loc_q_ready_i[q_idx_q];
      else if (q_tgt_q == TGT_NXT) held_ready = bus.nxt_q_ready_i;
    end
  end

  // An error request never occupies the request register, only the error entry.
  assign err_gnt           = src_ready[0];
  assign bus.slv_q_ready_o = (~q_full_q | held_ready) &
                             ~((in_tgt == TGT_ERR) & err_full_q & ~err_gnt);
  assign in_acc            = bus.slv_q_valid_i & bus.slv_q_ready_o;

  always_comb begin
    q_full_d   = q_full_q & ~held_ready;
    q_tgt_d    = q_tgt_q;
    q_idx_d    = q_idx_q;
    q_req_d    = q_req_q;
    err_full_d = err_full_q & ~err_gnt;
    err_id_d   = err_id_q;
    if (in_acc) begin
      if (in_tgt == TGT_ERR) begin
        err_full_d = 1'b1;
        err_id_d   = bus.slv_q_id_i;
      end else begin
        q_full_d = 1'b1;
        q_tgt_d  = in_tgt;
        q_idx_d  = in_idx;
        q_req_d  = '{addr: bus.slv_q_addr_i, id: bus.slv_q_id_i,
                     instr: bus.slv_q_instr_i, rs: bus.slv_q_rs_i};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_full_q   <= 1'b0;
      q_tgt_q    <= TGT_LOC;
      q_idx_q    <= '0;
      q_req_q    <= '0;
      err_full_q <= 1'b0;
      err_id_q   <= '0;
    end else begin
      q_full_q   <= q_full_d;
      q_tgt_q    <= q_tgt_d;
      q_idx_q    <= q_idx_d;
      q_req_q    <= q_req_d;
      err_full_q <= err_full_d;
      err_id_q   <= err_id_d;
    end
  end

  always_comb begin
    loc_q_valid = '0;
    if (q_full_q && q_tgt_q == TGT_LOC) loc_q_valid[q_idx_q] = 1'b1;
  end

  assign bus.loc_q_valid_o = loc_q_valid;
  assign bus.nxt_q_valid_o = q_full_q & (q_tgt_q == TGT_NXT);
  assign bus.q_addr_o      = q_req_q.addr;
  assign bus.q_id_o        = q_req_q.id;
  assign bus.q_instr_o     = q_req_q.instr;
  assign bus.q_rs_o        = q_req_q.rs;

  // Source order sets priority: error entry, locals in index order, next level.
  always_comb begin
    src_valid[0] = err_full_q;
    src_rsp[0]   = '{error: 1'b1, id: err_id_q, data: '0};
    for (int i = 0; i < NumRsp; i++) begin
      src_valid[i+1] = bus.loc_p_valid_i[i];
      src_rsp[i+1]   = '{error: bus.loc_p_error_i[i],
                         id:    bus.loc_p_id_i[i*IdWidth +: IdWidth],
                         data:  bus.loc_p_data_i[i*DataWidth +: DataWidth]};
    end
    src_valid[NumSrc-1] = bus.nxt_p_valid_i;
    src_rsp[NumSrc-1]   = '{error: bus.nxt_p_error_i, id: bus.nxt_p_id_i, data: bus.nxt_p_data_i};
  end

  acc_rsp_arbiter #(
    .NumIn (NumSrc),
    .Width ($bits(rsp_t))
  ) u_rsp_arb (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (src_valid),
    .in_ready_o  (src_ready),
    .in_data_i   (src_rsp),
    .out_valid_o (bus.slv_p_valid_o),
    .out_ready_i (bus.slv_p_ready_i),
    .out_data_o  (out_rsp)
  );

  assign bus.loc_p_ready_o = src_ready[NumRsp:1];
  assign bus.nxt_p_ready_o = src_ready[NumSrc-1];
  assign bus.slv_p_data_o  = out_rsp.data;
  assign bus.slv_p_id_o    = out_rsp.id;
  assign bus.slv_p_error_o = out_rsp.error;
endmodule

// File: tb/tb_acc_interconnect_stage.sv
// Bench for acc_interconnect_stage at HierLevel=1, NumRsp=2: directed scenarios plus
// random traffic, all checked every cycle against a queue-based model of the stage.
module tb_acc_interconnect_stage;
  localparam int unsigned HL  = 1;
  localparam int unsigned NH  = 3;
  localparam int unsigned NR  = 2;
  localparam int unsigned HW  = 2;
  localparam int unsigned AW  = 2;
  localparam int unsigned ADW = HW + AW;
  localparam int unsigned DW  = 32;
  localparam int unsigned IW  = 1;
  localparam int unsigned NS  = NR + 2;
  localparam int unsigned RW  = DW + IW + 1;
  localparam int T_LOC = 0, T_NXT = 1, T_ERR = 2;

  typedef struct {
    int               tgt;
    int               idx;
    logic [ADW-1:0]   addr;
    logic [IW-1:0]    id;
    logic [31:0]      instr;
    logic [3*DW-1:0]  rs;
  } mreq_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  acc_interconnect_stage_if #(.NumRsp(NR), .AddrWidth(ADW), .DataWidth(DW), .IdWidth(IW)) bus ();

  acc_interconnect_stage #(
    .HierLevel(HL), .NumHier(NH), .NumRsp(NR), .HierAddrWidth(HW),
    .AccAddrWidth(AW), .DataWidth(DW), .IdWidth(IW)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // Model state: held request, pending error ids, response output slot {error,id,data}.
  mreq_t          req_q[$];
  logic [IW-1:0]  err_q[$];
  logic [RW-1:0]  exp_q[$];
  int             rr_ptr = 0;
  int             n_vec = 0;
  int             n_err = 0;
  bit             loc0_hs;
  bit             last_acc;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int decode(input logic [ADW-1:0] a);
    int hier, idx;
    hier = int'(a) / (1 << AW);
    idx  = int'(a) % (1 << AW);
    if (hier == int'(HL)) return (idx < int'(NR)) ? T_LOC : T_ERR;
    return (HL == NH - 1) ? T_ERR : T_NXT;
  endfunction

  // Compare one cycle against the model, then advance the model across the edge.
  task automatic cycle();
    bit             held, tgt_rdy, slot_free, in_err, exp_rdy, hs_in;
    bit [NS-1:0]    sv;
    logic [NR-1:0]  exp_loc_v, exp_lpr;
    int             win;
    mreq_t          in_req;
    logic [RW-1:0]  rsp;
    #1;
    held      = req_q.size() != 0;
    exp_loc_v = '0;
    tgt_rdy   = 1'b0;
    if (held) begin
      if (req_q[0].tgt == T_LOC) begin
        exp_loc_v[req_q[0].idx] = 1'b1;
        tgt_rdy = bus.loc_q_ready_i[req_q[0].idx];
      end else begin
        tgt_rdy = bus.nxt_q_ready_i;
      end
    end
    sv[0] = err_q.size() != 0;
    for (int i = 0; i < int'(NR); i++) sv[i+1] = bus.loc_p_valid_i[i];
    sv[NS-1]  = bus.nxt_p_valid_i;
    slot_free = (exp_q.size() == 0) || bus.slv_p_ready_i;
    win = -1;
    for (int k = 0; k < int'(NS); k++) begin
      int s;
      s = (rr_ptr + k) % int'(NS);
      if (win < 0 && sv[s]) win = s;
    end
    if (!slot_free) win = -1;
    in_err  = decode(bus.slv_q_addr_i) == T_ERR;
    exp_rdy = (!held || tgt_rdy) && !(in_err && err_q.size() != 0 && win != 0);
    exp_lpr = '0;
    if (win >= 1 && win <= int'(NR)) exp_lpr[win-1] = 1'b1;

    chk("slv_q_ready", bus.slv_q_ready_o, exp_rdy);
    chk("loc_q_valid", bus.loc_q_valid_o, exp_loc_v);
    if (held) begin
      chk("nxt_q_valid", bus.nxt_q_valid_o, req_q[0].tgt == T_NXT);
      chk("q_addr", bus.q_addr_o, req_q[0].addr);
      chk("q_id", bus.q_id_o, req_q[0].id);
      chk("q_instr", bus.q_instr_o, req_q[0].instr);
      chk("q_rs", bus.q_rs_o, req_q[0].rs);
    end else begin
      chk("nxt_q_valid", bus.nxt_q_valid_o, 1'b0);
    end
    chk("slv_p_valid", bus.slv_p_valid_o, exp_q.size() != 0);
    if (exp_q.size() != 0)
      chk("slv_p_rsp", {bus.slv_p_error_o, bus.slv_p_id_o, bus.slv_p_data_o}, exp_q[0]);
    chk("loc_p_ready", bus.loc_p_ready_o, exp_lpr);
    chk("nxt_p_ready", bus.nxt_p_ready_o, win == int'(NS) - 1);

    hs_in    = bus.slv_q_valid_i && exp_rdy;
    last_acc = hs_in;
    loc0_hs  = bus.loc_q_valid_o[0] && bus.loc_q_ready_i[0];
    in_req   = '{tgt: decode(bus.slv_q_addr_i), idx: int'(bus.slv_q_addr_i) % (1 << AW),
                 addr: bus.slv_q_addr_i, id: bus.slv_q_id_i,
                 instr: bus.slv_q_instr_i, rs: bus.slv_q_rs_i};
    rsp = '0;
    if (win == 0) rsp = {1'b1, err_q[0], {DW{1'b0}}};
    else if (win >= 1 && win <= int'(NR))
      rsp = {bus.loc_p_error_i[win-1], bus.loc_p_id_i[(win-1)*IW +: IW],
             bus.loc_p_data_i[(win-1)*DW +: DW]};
    else if (win == int'(NS) - 1) rsp = {bus.nxt_p_error_i, bus.nxt_p_id_i, bus.nxt_p_data_i};

    @(posedge clk);
    if (held && tgt_rdy) void'(req_q.pop_front());
    if (slot_free && exp_q.size() != 0) void'(exp_q.pop_front());
    if (win >= 0) begin
      exp_q.push_back(rsp);
      if (win == 0) void'(err_q.pop_front());
`ifdef ACC_IC_STAGE_RR_ARB_EN
      rr_ptr = (win + 1) % int'(NS);
`endif
    end
    if (hs_in) begin
      if (in_req.tgt == T_ERR) err_q.push_back(in_req.id);
      else req_q.push_back(in_req);
    end

    @(negedge clk);
    if (hs_in) bus.slv_q_valid_i = 1'b0;
    if (win >= 1 && win <= int'(NR)) bus.loc_p_valid_i[win-1] = 1'b0;
    if (win == int'(NS) - 1) bus.nxt_p_valid_i = 1'b0;
  endtask

  task automatic set_req(input logic [ADW-1:0] addr, input logic [IW-1:0] id, input logic [31:0] instr);
    bus.slv_q_valid_i = 1'b1;
    bus.slv_q_addr_i  = addr;
    bus.slv_q_id_i    = id;
    bus.slv_q_instr_i = instr;
    bus.slv_q_rs_i    = {$urandom, $urandom, $urandom};
  endtask

  task automatic clear_inputs();
    bus.slv_q_valid_i = 1'b0;
    bus.loc_p_valid_i = '0;
    bus.nxt_p_valid_i = 1'b0;
    bus.loc_q_ready_i = '1;
    bus.nxt_q_ready_i = 1'b1;
    bus.slv_p_ready_i = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_slv_q_ready", bus.slv_q_ready_o, 1'b1);
    chk("rst_loc_q_valid", bus.loc_q_valid_o, 2'b00);
    chk("rst_nxt_q_valid", bus.nxt_q_valid_o, 1'b0);
    chk("rst_slv_p_valid", bus.slv_p_valid_o, 1'b0);
    chk("rst_q_instr", bus.q_instr_o, 32'h0);
    chk("rst_slv_p_data", bus.slv_p_data_o, 32'h0);
    req_q.delete();
    err_q.delete();
    exp_q.delete();
    rr_ptr = 0;
    rst = 1'b0;
  endtask

  task automatic quiesce();
    int n;
    n = 0;
    bus.loc_q_ready_i = '1;
    bus.nxt_q_ready_i = 1'b1;
    bus.slv_p_ready_i = 1'b1;
    while ((bus.slv_q_valid_i || bus.loc_p_valid_i != 0 || bus.nxt_p_valid_i ||
            req_q.size() != 0 || err_q.size() != 0 || exp_q.size() != 0) && n < 30) begin
      cycle();
      n++;
    end
    chk("quiesce_timeout", n >= 30, 1'b0);
  endtask

  task automatic rand_inputs();
    if (!bus.slv_q_valid_i && $urandom_range(0, 99) < 60)
      set_req(ADW'($urandom_range(0, 15)), IW'($urandom_range(0, 1)), $urandom);
    bus.loc_q_ready_i = NR'($urandom_range(0, 3));
    bus.nxt_q_ready_i = $urandom_range(0, 99) < 70;
    bus.slv_p_ready_i = $urandom_range(0, 99) < 70;
    for (int i = 0; i < int'(NR); i++) begin
      if (!bus.loc_p_valid_i[i] && $urandom_range(0, 99) < 40) begin
        bus.loc_p_valid_i[i]            = 1'b1;
        bus.loc_p_data_i[i*DW +: DW]    = $urandom;
        bus.loc_p_id_i[i*IW +: IW]      = IW'($urandom_range(0, 1));
        bus.loc_p_error_i[i]            = $urandom_range(0, 9) == 0;
      end
    end
    if (!bus.nxt_p_valid_i && $urandom_range(0, 99) < 40) begin
      bus.nxt_p_valid_i = 1'b1;
      bus.nxt_p_data_i  = $urandom;
      bus.nxt_p_id_i    = IW'($urandom_range(0, 1));
      bus.nxt_p_error_i = $urandom_range(0, 9) == 0;
    end
  endtask

  initial begin
    int hs_cnt, acc_cnt;
    bus.slv_q_addr_i  = '0;
    bus.slv_q_id_i    = '0;
    bus.slv_q_instr_i = '0;
    bus.slv_q_rs_i    = '0;
    bus.loc_p_data_i  = '0;
    bus.loc_p_id_i    = '0;
    bus.loc_p_error_i = '0;
    bus.nxt_p_data_i  = '0;
    bus.nxt_p_id_i    = '0;
    bus.nxt_p_error_i = 1'b0;
    do_reset();

    // Local request to {hier=1, idx=1}
    bus.loc_q_ready_i = '0;
    set_req(4'h5, 1'b0, 32'hDEADBEEF);
    cycle();
    chk("t1_loc_q_valid", bus.loc_q_valid_o, 2'b10);
    chk("t1_q_instr", bus.q_instr_o, 32'hDEADBEEF);
    chk("t1_nxt_q_valid", bus.nxt_q_valid_o, 1'b0);
    quiesce();

    // Next-level request held by back-pressure, with a second request waiting behind it
    bus.nxt_q_ready_i = 1'b0;
    set_req(4'h8, 1'b1, 32'hCAFE0002);
    cycle();
    set_req(4'h4, 1'b0, 32'h12345678);
    for (int c = 0; c < 5; c++) begin
      chk("t2_nxt_q_valid", bus.nxt_q_valid_o, 1'b1);
      chk("t2_q_instr", bus.q_instr_o, 32'hCAFE0002);
      chk("t2_q_addr", bus.q_addr_o, 4'h8);
      chk("t2_slv_q_ready", bus.slv_q_ready_o, 1'b0);
      cycle();
    end
    bus.nxt_q_ready_i = 1'b1;
    cycle();
    chk("t2_reload_loc_q_valid", bus.loc_q_valid_o, 2'b01);
    chk("t2_reload_q_instr", bus.q_instr_o, 32'h12345678);
    quiesce();

    // Unmapped local index produces an error response
    set_req(4'h7, 1'b1, 32'h0BAD0BAD);
    cycle();
    chk("t3_loc_q_valid", bus.loc_q_valid_o, 2'b00);
    chk("t3_nxt_q_valid", bus.nxt_q_valid_o, 1'b0);
    cycle();
    chk("t3_err_rsp", {bus.slv_p_valid_o, bus.slv_p_error_o, bus.slv_p_id_o, bus.slv_p_data_o},
        {1'b1, 1'b1, 1'b1, 32'h0});
    quiesce();

    // Three simultaneous responses drain in priority order
    bus.loc_p_valid_i = 2'b11;
    bus.loc_p_data_i  = {32'h22, 32'h11};
    bus.loc_p_id_i    = '0;
    bus.loc_p_error_i = '0;
    bus.nxt_p_valid_i = 1'b1;
    bus.nxt_p_data_i  = 32'h33;
    bus.nxt_p_id_i    = '0;
    bus.nxt_p_error_i = 1'b0;
    cycle();
    chk("t4_rsp0", {bus.slv_p_valid_o, bus.slv_p_data_o}, {1'b1, 32'h11});
    cycle();
    chk("t4_rsp1", {bus.slv_p_valid_o, bus.slv_p_data_o}, {1'b1, 32'h22});
    cycle();
    chk("t4_rsp2", {bus.slv_p_valid_o, bus.slv_p_data_o}, {1'b1, 32'h33});
    quiesce();

    // Back-to-back requests to local 0
    hs_cnt  = 0;
    acc_cnt = 0;
    for (int k = 0; k <= 100; k++) begin
      if (k < 100) set_req(4'h4, 1'b0, 32'(k));
      cycle();
      if (loc0_hs) hs_cnt++;
      if (last_acc) acc_cnt++;
    end
    chk("t5_accepts", 32'(acc_cnt), 32'd100);
    chk("t5_loc0_handshakes", 32'(hs_cnt), 32'd100);
    quiesce();

    // Reset while both registers hold traffic
    bus.nxt_q_ready_i = 1'b0;
    bus.slv_p_ready_i = 1'b0;
    set_req(4'h8, 1'b0, 32'hA5A5A5A5);
    bus.loc_p_valid_i[0]       = 1'b1;
    bus.loc_p_data_i[0 +: DW]  = 32'h55;
    cycle();
    chk("t6_pre_nxt_q_valid", bus.nxt_q_valid_o, 1'b1);
    chk("t6_pre_slv_p_valid", bus.slv_p_valid_o, 1'b1);
    do_reset();
    repeat (5) cycle();

    for (int k = 0; k < 1500; k++) begin
      rand_inputs();
      cycle();
    end
    quiesce();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 1000000");
    $fatal(1, "watchdog");
  end
endmodule
